// File: rtl/sram_1r1w_param.sv
`timescale 1ns/1ps
// sram_1r1w_param
// Behavioural single-clock 1-read/1-write SRAM with parametrised width,
// depth and write-mask lane size. Read latency is 1 or 2 cycles, and
// same-address read-during-write can return either the new or the old data.
// An optional sequencer zeroes every entry after reset. Read and write
// requests are ignored while it runs.
module sram_1r1w_param #(
   parameter int DATA_WIDTH     = 64,
   parameter int DEPTH          = 512,
   parameter int MASK_GRAN      = 8,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 1,
   parameter int CLEAR_ON_RESET = 1,
   localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int MW            = DATA_WIDTH / MASK_GRAN
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  W0_en,
   input  logic [AW-1:0]         W0_addr,
   input  logic [DATA_WIDTH-1:0] W0_data,
   input  logic [MW-1:0]         W0_mask,
   input  logic                  R0_en,
   input  logic [AW-1:0]         R0_addr,
   output logic [DATA_WIDTH-1:0] R0_data,
   output logic                  R0_valid,
   output logic                  init_busy
);

   localparam logic [0:0]    ST_CLEAR   = 1'b0;
   localparam logic [0:0]    ST_READY   = 1'b1;
   localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT  = (AW + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]            state;
   logic [AW-1:0]         clr_cnt;
   logic                  clearing;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_fire;
   logic                  rd_fire;
   logic                  same_addr;
   logic [DATA_WIDTH-1:0] rd_word;

   // The reset state is also the busy indication. Once READY, requests are accepted.
   assign clearing    = (state == ST_CLEAR);
   assign init_busy   = clearing;
   assign wr_in_range = ({1'b0, W0_addr} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, R0_addr} < DEPTH_EXT);
   assign wr_fire     = W0_en && !clearing && wr_in_range;
   assign rd_fire     = R0_en && !clearing;
   assign same_addr   = wr_fire && (W0_addr == R0_addr);

   // Clear sequencer: one entry per cycle from 0 to DEPTH-1, then stay READY until reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         if (clr_cnt == LAST_ENTRY) begin
            state <= ST_READY;
         end else begin
            clr_cnt <= clr_cnt + AW'(1);
         end
      end
   end

   // Array update. The clear sequencer has priority, and user writes apply lane by lane.
   always_ff @(posedge clock) begin
      if (clearing) begin
         mem[clr_cnt] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < MW; i++) begin
            if (W0_mask[i]) begin
               mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Read word as seen at the accepting edge. Out-of-range reads return zero. Same-address writes are optionally merged per lane.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[R0_addr];
         if ((WRITE_FIRST != 0) && same_addr) begin
            for (int i = 0; i < MW; i++) begin
               if (W0_mask[i]) begin
                  rd_word[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
               end
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] s1_data;
         logic                  s1_valid;

         // Two-stage read pipeline: the array read is registered, then moved to the held output register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               s1_data  <= '0;
               s1_valid <= 1'b0;
               R0_data  <= '0;
               R0_valid <= 1'b0;
            end else begin
               s1_valid <= rd_fire;
               if (rd_fire) begin
                  s1_data <= rd_word;
               end
               R0_valid <= s1_valid;
               if (s1_valid) begin
                  R0_data <= s1_data;
               end
            end
         end
      end else begin : g_lat1
         // Single-stage read: the output register loads only on accepted reads, so the data holds between valids.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               R0_data  <= '0;
               R0_valid <= 1'b0;
            end else begin
               R0_valid <= rd_fire;
               if (rd_fire) begin
                  R0_data <= rd_word;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sram_1r1w_param.sv
`timescale 1ns/1ps
// tb_sram_1r1w_param
// Directed bench driving two SRAM configurations from the same inputs:
//   dut_a: DEPTH 512, READ_LATENCY 1, WRITE_FIRST 1
//   dut_b: DEPTH 300, READ_LATENCY 2, WRITE_FIRST 0
// Each call to applyStimulus is one clock cycle. Outputs are sampled 1ns after the rising edge.
module tb_sram_1r1w_param;

   logic        clock;
   logic        reset_n;
   logic        w_en;
   logic [8:0]  w_addr;
   logic [63:0] w_data;
   logic [7:0]  w_mask;
   logic        r_en;
   logic [8:0]  r_addr;

   logic [63:0] data_a, data_b;
   logic        valid_a, valid_b;
   logic        busy_a, busy_b;

   int n_checks;
   int n_fail;
   int cnt_a, cnt_b;
   logic saw_valid;

   sram_1r1w_param #(
      .DATA_WIDTH(64), .DEPTH(512), .MASK_GRAN(8),
      .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clock(clock), .reset_n(reset_n),
      .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
      .R0_en(r_en), .R0_addr(r_addr),
      .R0_data(data_a), .R0_valid(valid_a), .init_busy(busy_a)
   );

   sram_1r1w_param #(
      .DATA_WIDTH(64), .DEPTH(300), .MASK_GRAN(8),
      .READ_LATENCY(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clock(clock), .reset_n(reset_n),
      .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
      .R0_en(r_en), .R0_addr(r_addr),
      .R0_data(data_b), .R0_valid(valid_b), .init_busy(busy_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle's worth of requests, then advance past the next rising edge.
   task automatic applyStimulus(input logic we, input logic [8:0] wa, input logic [63:0] wd,
                                input logic [7:0] wm, input logic re, input logic [8:0] ra);
      w_en   = we;
      w_addr = wa;
      w_data = wd;
      w_mask = wm;
      r_en   = re;
      r_addr = ra;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Count busy cycles of both instances after reset release, pulsing R0_en early in the clear.
   task automatic measureClear();
      cnt_a = 0;
      cnt_b = 0;
      saw_valid = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (busy_a) cnt_a++;
         if (busy_b) cnt_b++;
         if (!busy_a && !busy_b && i >= 8) break;
         applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, (i < 5), 9'd0);
         saw_valid = saw_valid | valid_a | valid_b;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0; r_en = 1'b0; r_addr = '0;
      #23;

      $display("[TB] reset state");
      checkOutput("rst_data_a",  data_a,  64'd0);
      checkOutput("rst_valid_a", valid_a, 64'd0);
      checkOutput("rst_busy_a",  busy_a,  64'd1);
      checkOutput("rst_data_b",  data_b,  64'd0);
      checkOutput("rst_valid_b", valid_b, 64'd0);
      checkOutput("rst_busy_b",  busy_b,  64'd1);

      @(posedge clock);
      #1;
      reset_n = 1'b1;

      $display("[TB] T1 clear sequence");
      measureClear();
      checkOutput("t1_busy_cycles_a", cnt_a, 64'd512);
      checkOutput("t1_busy_cycles_b", cnt_b, 64'd300);
      checkOutput("t1_no_valid_busy", saw_valid, 64'd0);

      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h000);
      checkOutput("t1_rd0_valid_a", valid_a, 64'd1);
      checkOutput("t1_rd0_data_a",  data_a,  64'd0);
      checkOutput("t1_rd0_early_b", valid_b, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h1FF);
      checkOutput("t1_rd1ff_valid_a", valid_a, 64'd1);
      checkOutput("t1_rd1ff_data_a",  data_a,  64'd0);
      checkOutput("t1_rd0_valid_b",   valid_b, 64'd1);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t1_idle_valid_a",  valid_a, 64'd0);
      checkOutput("t1_rd1ff_valid_b", valid_b, 64'd1);
      checkOutput("t1_rd1ff_data_b",  data_b,  64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t1_idle_valid_b",  valid_b, 64'd0);

      $display("[TB] T2 masked writes");
      applyStimulus(1'b1, 9'h010, 64'h1122334455667788, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b1, 9'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 9'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h010);
      checkOutput("t2_data_a", data_a, 64'h11223344AAAAAAAA);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t2_data_b", data_b, 64'h11223344AAAAAAAA);
      checkOutput("t2_valid_b", valid_b, 64'd1);

      $display("[TB] T3 read during write");
      applyStimulus(1'b1, 9'h010, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b1, 9'h010);
      checkOutput("t3_wfirst_a", data_a, 64'hFFFFFFFFAAAAAAAA);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t3_rfirst_b", data_b, 64'h11223344AAAAAAAA);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h010);
      checkOutput("t3_after_a", data_a, 64'hFFFFFFFFAAAAAAAA);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t3_after_b", data_b, 64'hFFFFFFFFAAAAAAAA);

      $display("[TB] write then read next cycle");
      applyStimulus(1'b1, 9'h020, 64'h0000000000000077, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h020);
      checkOutput("haz_data_a", data_a, 64'h77);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("haz_data_b", data_b, 64'h77);

      $display("[TB] T4 pipelined burst");
      applyStimulus(1'b1, 9'h001, 64'h101, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b1, 9'h002, 64'h202, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b1, 9'h003, 64'h303, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h001);
      checkOutput("t4_c1_data_a",  data_a,  64'h101);
      checkOutput("t4_c1_valid_b", valid_b, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h002);
      checkOutput("t4_c2_data_a",  data_a,  64'h202);
      checkOutput("t4_c2_valid_b", valid_b, 64'd1);
      checkOutput("t4_c2_data_b",  data_b,  64'h101);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h003);
      checkOutput("t4_c3_data_a",  data_a,  64'h303);
      checkOutput("t4_c3_valid_b", valid_b, 64'd1);
      checkOutput("t4_c3_data_b",  data_b,  64'h202);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t4_c4_valid_a", valid_a, 64'd0);
      checkOutput("t4_c4_valid_b", valid_b, 64'd1);
      checkOutput("t4_c4_data_b",  data_b,  64'h303);
      applyStimulus(1'b1, 9'h003, 64'hBAD, 8'hFF, 1'b0, 9'd0);
      checkOutput("t4_c5_valid_b", valid_b, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t4_hold_a", data_a, 64'h303);
      checkOutput("t4_hold_b", data_b, 64'h303);

      $display("[TB] T6 range and empty mask");
      applyStimulus(1'b1, 9'd54,  64'h5454, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b1, 9'd310, 64'hDEAD, 8'hFF, 1'b0, 9'd0);
      applyStimulus(1'b1, 9'd54,  64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 9'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd310);
      checkOutput("t6_in_range_a", data_a, 64'hDEAD);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd54);
      checkOutput("t6_e54_a",        data_a,  64'h5454);
      checkOutput("t6_oor_valid_b",  valid_b, 64'd1);
      checkOutput("t6_oor_data_b",   data_b,  64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t6_e54_b", data_b, 64'h5454);

      $display("[TB] T5 reset during clear");
      reset_n = 1'b0;
      #2;
      checkOutput("t5_async_data_a",  data_a,  64'd0);
      checkOutput("t5_async_data_b",  data_b,  64'd0);
      checkOutput("t5_async_valid_b", valid_b, 64'd0);
      checkOutput("t5_busy_a",        busy_a,  64'd1);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      end
      checkOutput("t5_mid_busy_a", busy_a, 64'd1);
      reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      measureClear();
      checkOutput("t5_busy_cycles_a", cnt_a, 64'd512);
      checkOutput("t5_busy_cycles_b", cnt_b, 64'd300);
      checkOutput("t5_no_valid_busy", saw_valid, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'h010);
      checkOutput("t5_cleared_valid_a", valid_a, 64'd1);
      checkOutput("t5_cleared_a", data_a, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd54);
      checkOutput("t5_cleared_b", data_b, 64'd0);
      applyStimulus(1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
      checkOutput("t5_cleared54_a", data_a, 64'd0);
      checkOutput("t5_cleared54_b", data_b, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
